hex_marquee_scroller: RTL and testbench
=======================================

Name: hex_marquee_scroller

Overview:
Parametrised scrolling-text engine for the board's seven-segment bank. It holds a writable message buffer of character codes and rotates a window of NUM_DIGITS characters across it at a programmable rate. Direction, enable, single-step and runtime message length are controllable. The per-digit codes feed the existing per-digit charToHex decoders, one instance per digit, outside this block.

Parameters:
NUM_DIGITS, 6, number of display digits driven (≥1)
MSG_LEN, 18, message buffer depth in characters (must be ≥ NUM_DIGITS)
CODE_W, 5, character code width (matches charToHex input)
TICK_DIV, 12500000, CLOCK_50 cycles per scroll step (≥2); 12.5M gives 4 steps/s

Ports:
CLOCK_50  in  1  system clock
resetn  in  1  asynchronous active-low reset
enable  in  1  1 = auto-scroll on divider tick
dir  in  1  0 = scroll left (ptr increments), 1 = scroll right (ptr decrements)
step  in  1  single-cycle pulse; forces one scroll step
msg_len  in  $clog2(MSG_LEN+1)  active message length
wr_en  in  1  buffer write strobe
wr_addr  in  $clog2(MSG_LEN)  buffer write index
wr_data  in  CODE_W  character code to write
digit_codes  out  NUM_DIGITS*CODE_W  slice k (bits k*CODE_W +: CODE_W) drives hex digit k; k=0 is rightmost
scroll_pos  out  $clog2(MSG_LEN)  current window start pointer
wrap_pulse  out  1  one-cycle pulse when the pointer wraps

Behaviour:
- Reset (async assert, sync release): buffer entry i = (MSG_LEN-1-i) mod 2^CODE_W; ptr=0; divider=0; wrap_pulse=0. digit_codes shows the window at ptr=0, e.g. digit5=17, digit0=12 for defaults.
- Effective length L: msg_len clamped to [NUM_DIGITS, MSG_LEN]. Values 0 and values below NUM_DIGITS give NUM_DIGITS; values above MSG_LEN give MSG_LEN.
- Divider: counts 0..TICK_DIV-1 while enable=1. tick=1 in the cycle count==TICK_DIV-1, then count returns to 0. While enable=0 the count is held at 0, so the first tick comes TICK_DIV cycles after enable rises.
- Advance = tick OR step. Tick and step in the same cycle give exactly one step. step is honoured regardless of enable.
- On advance, dir=0: ptr = (ptr==L-1) ? 0 : ptr+1. dir=1: ptr = (ptr==0) ? L-1 : ptr-1.
- wrap_pulse: registered, high for the single cycle after a wrapping update in either direction.
- If ptr ≥ L because L shrank, ptr is forced to 0 on the next cycle. This takes priority over advance, and wrap_pulse stays 0.
- Window: the left-position j (0..NUM_DIGITS-1) holds buf[(ptr+j) mod L] and drives digit k = NUM_DIGITS-1-j. The mod is a single conditional subtract, which is legal because ptr+j < 2L.
- digit_codes and scroll_pos are registered: 1-cycle latency after a ptr or buffer change.
- Write: on wr_en, buf[wr_addr] <= wr_data. wr_addr ≥ MSG_LEN is ignored. A write landing in the visible window appears on digit_codes 2 cycles after the wr_en cycle (write cycle + output register). A write and an advance in the same cycle are both applied.
- Reset mid-scroll: all state returns to its reset values immediately, including buffer contents.

Decomposition:
- Shared package marquee_pkg: CODE_W default, blank-character code constant, dir encoding constants DIR_LEFT=0 / DIR_RIGHT=1.
- One sub-module: marquee_tick_gen (TICK_DIV counter with enable-hold, produces tick). Everything else lives in hex_marquee_scroller.

Test Plan (TICK_DIV=4, defaults otherwise):
- Reset then enable=1, dir=0, msg_len=18 -> tick every 4 cycles; after 1 step digit5=16, digit0=11; after 18 steps ptr=0 with wrap_pulse high for exactly one cycle.
- dir=1 from reset, one step -> ptr=17, digit5=buf[17]=0, digit4=buf[0]=17, wrap_pulse pulses once.
- enable=0 with a step pulse every 10 cycles -> exactly one advance per pulse. Then raise step in the same cycle as a tick -> single advance, ptr +1 only.
- msg_len=3 -> L clamps to 6 and ptr cycles 0..5. With ptr=10 and msg_len=18, change msg_len to 8 -> ptr=0 next cycle and wrap_pulse stays 0.
- Write wr_addr=1, wr_data=5'h1F while ptr=0 -> digit4=31 two cycles later. Write to wr_addr=18 -> no buffer change.
- Assert resetn=0 mid-scroll, asynchronously between clock edges -> outputs return to reset values before the next edge; the divider restarts from 0 after release.

Source files
------------

// File: rtl/marquee_pkg.sv
// Shared constants for the seven-segment marquee engine.
// Character code width, blank code and scroll direction encoding.
package marquee_pkg;

   localparam int   DEF_CODE_W = 5;
   localparam int   BLANK_CODE = 31;
   localparam logic DIR_LEFT   = 1'b0;
   localparam logic DIR_RIGHT  = 1'b1;

endpackage

// File: rtl/marquee_tick_gen.sv
// Scroll-rate divider: one tick every TICK_DIV cycles while enabled.
// The count is parked at zero whenever enable is low.
module marquee_tick_gen #(
   parameter int TICK_DIV = 12500000
) (
   input  logic CLOCK_50,
   input  logic resetn,
   input  logic enable,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);

   logic [CW-1:0] count;

   assign tick = enable && (count == CW'(TICK_DIV - 1));

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (!enable || tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hex_marquee_scroller.sv
// Scrolling window of NUM_DIGITS characters over a writable message buffer.
// Window, pointer and wrap flag are all registered outputs.
module hex_marquee_scroller
   import marquee_pkg::*;
#(
   parameter int  NUM_DIGITS = 6,
   parameter int  MSG_LEN    = 18,
   parameter int  CODE_W     = DEF_CODE_W,
   parameter int  TICK_DIV   = 12500000,
   localparam int LW = $clog2(MSG_LEN + 1),
   localparam int PW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
   input  logic                         CLOCK_50,
   input  logic                         resetn,
   input  logic                         enable,
   input  logic                         dir,
   input  logic                         step,
   input  logic [LW-1:0]                msg_len,
   input  logic                         wr_en,
   input  logic [PW-1:0]                wr_addr,
   input  logic [CODE_W-1:0]            wr_data,
   output logic [NUM_DIGITS*CODE_W-1:0] digit_codes,
   output logic [PW-1:0]                scroll_pos,
   output logic                         wrap_pulse
);

   localparam int IW = LW + 1;
   localparam int DW = NUM_DIGITS * CODE_W;

   function automatic logic [DW-1:0] reset_window();
      logic [DW-1:0] w;
      w = '0;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         w[(NUM_DIGITS-1-j)*CODE_W +: CODE_W] = CODE_W'(MSG_LEN - 1 - j);
      end
      return w;
   endfunction

   localparam logic [DW-1:0] RST_WIN = reset_window();

   logic [CODE_W-1:0] msg_buf [MSG_LEN];
   logic [PW-1:0]     ptr;
   logic [PW-1:0]     last;
   logic [LW-1:0]     len_eff;
   logic [IW-1:0]     idx;
   logic [DW-1:0]     window;
   logic              tick;
   logic              advance;
   logic              ptr_oor;

   marquee_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .CLOCK_50 (CLOCK_50),
      .resetn   (resetn),
      .enable   (enable),
      .tick     (tick)
   );

   always_comb begin
      len_eff = msg_len;
      if (msg_len < LW'(NUM_DIGITS)) begin
         len_eff = LW'(NUM_DIGITS);
      end else if (msg_len > LW'(MSG_LEN)) begin
         len_eff = LW'(MSG_LEN);
      end
   end

   assign last    = PW'(len_eff - 1'b1);
   assign advance = tick || step;
   assign ptr_oor = IW'(ptr) >= IW'(len_eff);

   // ptr+j < 2L, so one conditional subtract implements the modulo
   always_comb begin
      window = '0;
      idx    = '0;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         idx = IW'(ptr) + IW'(j);
         if (idx >= IW'(len_eff)) begin
            idx = idx - IW'(len_eff);
         end
         if (idx < IW'(MSG_LEN)) begin
            window[(NUM_DIGITS-1-j)*CODE_W +: CODE_W] = msg_buf[idx[PW-1:0]];
         end else begin
            window[(NUM_DIGITS-1-j)*CODE_W +: CODE_W] = CODE_W'(BLANK_CODE);
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < MSG_LEN; i++) begin
            msg_buf[i] <= CODE_W'(MSG_LEN - 1 - i);
         end
      end else if (wr_en && (IW'(wr_addr) < IW'(MSG_LEN))) begin
         msg_buf[wr_addr] <= wr_data;
      end
   end

   // a shrunken length pulls ptr home before any scroll step
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         ptr        <= '0;
         wrap_pulse <= 1'b0;
      end else begin
         wrap_pulse <= 1'b0;
         if (ptr_oor) begin
            ptr <= '0;
         end else if (advance) begin
            if (dir == DIR_LEFT) begin
               if (ptr == last) begin
                  ptr        <= '0;
                  wrap_pulse <= 1'b1;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end else begin
               if (ptr == '0) begin
                  ptr        <= last;
                  wrap_pulse <= 1'b1;
               end else begin
                  ptr <= ptr - 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         digit_codes <= RST_WIN;
         scroll_pos  <= '0;
      end else begin
         digit_codes <= window;
         scroll_pos  <= ptr;
      end
   end

endmodule

// File: tb/tb_hex_marquee_scroller.sv
// Bench for hex_marquee_scroller: directed table, corner sequences,
// and random stimulus against an arithmetic reference model.
module tb_hex_marquee_scroller;

   localparam int ND  = 6;
   localparam int ML  = 18;
   localparam int CW  = 5;
   localparam int TD  = 4;

   logic          CLOCK_50 = 1'b0;
   logic          resetn   = 1'b0;
   logic          enable   = 1'b0;
   logic          dir      = 1'b0;
   logic          step     = 1'b0;
   logic [4:0]    msg_len  = 5'd18;
   logic          wr_en    = 1'b0;
   logic [4:0]    wr_addr  = '0;
   logic [CW-1:0] wr_data  = '0;
   logic [ND*CW-1:0] digit_codes;
   logic [4:0]    scroll_pos;
   logic          wrap_pulse;

   int errors = 0;
   int checks = 0;

   hex_marquee_scroller #(
      .NUM_DIGITS (ND),
      .MSG_LEN    (ML),
      .CODE_W     (CW),
      .TICK_DIV   (TD)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .resetn      (resetn),
      .enable      (enable),
      .dir         (dir),
      .step        (step),
      .msg_len     (msg_len),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .digit_codes (digit_codes),
      .scroll_pos  (scroll_pos),
      .wrap_pulse  (wrap_pulse)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // reference model state
   int mbuf [ML];
   int mptr;
   int mrun;
   int e_pos;
   int e_wrap;
   int e_dig [ND];
   bit e_valid;

   function automatic int eff_len(input int m);
      if (m < ND) return ND;
      if (m > ML) return ML;
      return m;
   endfunction

   function automatic int dig(input int k);
      return int'(digit_codes[k*CW +: CW]);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < ML; i++) mbuf[i] = ML - 1 - i;
      mptr    = 0;
      mrun    = 0;
      e_pos   = 0;
      e_wrap  = 0;
      e_valid = 1'b1;
      for (int k = 0; k < ND; k++) e_dig[k] = mbuf[ND - 1 - k];
   endtask

   task automatic model_edge();
      int  len;
      bit  tk;
      len     = eff_len(int'(msg_len));
      e_pos   = mptr;
      e_valid = (mptr < len);
      if (e_valid) begin
         for (int k = 0; k < ND; k++)
            e_dig[k] = mbuf[(mptr + ND - 1 - k) % len];
      end
      tk = 1'b0;
      if (enable) begin
         mrun++;
         tk = (mrun % TD) == 0;
      end else begin
         mrun = 0;
      end
      e_wrap = 0;
      if (mptr >= len) begin
         mptr = 0;
      end else if (tk || step) begin
         if (dir == 1'b0) begin
            mptr   = (mptr + 1) % len;
            e_wrap = (mptr == 0);
         end else begin
            e_wrap = (mptr == 0);
            mptr   = (mptr + len - 1) % len;
         end
      end
      if (wr_en && wr_addr < ML) mbuf[wr_addr] = int'(wr_data);
   endtask

   task automatic check_outputs();
      chk("scroll_pos", int'(scroll_pos), e_pos);
      chk("wrap_pulse", int'(wrap_pulse), e_wrap);
      if (e_valid) begin
         for (int k = 0; k < ND; k++)
            chk($sformatf("digit%0d", k), dig(k), e_dig[k]);
      end
   endtask

   task automatic cycle();
      @(posedge CLOCK_50);
      model_edge();
      @(negedge CLOCK_50);
      check_outputs();
   endtask

   typedef struct {
      logic       en;
      logic       dr;
      logic       stp;
      logic [4:0] mlen;
      logic       wen;
      logic [4:0] waddr;
      logic [4:0] wdata;
      int         ncyc;
      int         pos;
      int         wrap;
      int         d5;
      int         d4;
      int         d0;
   } vec_t;

   vec_t vt [14];

   initial begin
      vt[0]  = '{0, 0, 0, 18, 0, 0, 0,  0,  0, 0, 17, 16, 12};
      vt[1]  = '{0, 0, 1, 18, 0, 0, 0,  2,  1, 0, 16, 15, 11};
      vt[2]  = '{0, 1, 1, 18, 0, 0, 0,  2,  0, 0, 17, 16, 12};
      vt[3]  = '{0, 1, 1, 18, 0, 0, 0,  1,  0, 1, 17, 16, 12};
      vt[4]  = '{0, 1, 0, 18, 0, 0, 0,  1, 17, 0,  0, 17, 13};
      vt[5]  = '{0, 0, 1, 18, 0, 0, 0,  1, 17, 1,  0, 17, 13};
      vt[6]  = '{0, 0, 0, 18, 0, 0, 0,  1,  0, 0, 17, 16, 12};
      vt[7]  = '{1, 0, 0,  3, 0, 0, 0, 24,  5, 1, 12, 17, 13};
      vt[8]  = '{0, 0, 0, 18, 0, 0, 0,  1,  0, 0, 17, 16, 12};
      vt[9]  = '{1, 0, 0, 18, 0, 0, 0, 72, 17, 1,  0, 17, 13};
      vt[10] = '{0, 0, 0, 18, 0, 0, 0,  1,  0, 0, 17, 16, 12};
      vt[11] = '{0, 0, 0, 18, 1, 1, 31, 1,  0, 0, 17, 16, 12};
      vt[12] = '{0, 0, 0, 18, 0, 0, 0,  1,  0, 0, 17, 31, 12};
      vt[13] = '{0, 0, 0, 18, 1, 18, 0, 2,  0, 0, 17, 31, 12};

      model_reset();
      repeat (2) @(negedge CLOCK_50);
      resetn = 1'b1;

      for (int r = 0; r < 14; r++) begin
         enable  = vt[r].en;
         dir     = vt[r].dr;
         step    = vt[r].stp;
         msg_len = vt[r].mlen;
         wr_en   = vt[r].wen;
         wr_addr = vt[r].waddr;
         wr_data = vt[r].wdata;
         if (vt[r].ncyc == 0) check_outputs();
         for (int c = 0; c < vt[r].ncyc; c++) begin
            cycle();
            step  = 1'b0;
            wr_en = 1'b0;
         end
         chk($sformatf("row%0d pos", r), int'(scroll_pos), vt[r].pos);
         chk($sformatf("row%0d wrap", r), int'(wrap_pulse), vt[r].wrap);
         chk($sformatf("row%0d d5", r), dig(5), vt[r].d5);
         chk($sformatf("row%0d d4", r), dig(4), vt[r].d4);
         chk($sformatf("row%0d d0", r), dig(0), vt[r].d0);
      end

      // step coinciding with a divider tick
      enable = 1'b1;
      dir    = 1'b0;
      repeat (3) cycle();
      step = 1'b1;
      cycle();
      step   = 1'b0;
      enable = 1'b0;
      cycle();
      chk("tick+step pos", int'(scroll_pos), 1);

      for (int p = 0; p < 3; p++) begin
         step = 1'b1;
         cycle();
         step = 1'b0;
         repeat (9) cycle();
         chk($sformatf("pulse%0d pos", p), int'(scroll_pos), 2 + p);
      end

      for (int p = 0; p < 6; p++) begin
         step = 1'b1;
         cycle();
         step = 1'b0;
         cycle();
      end
      chk("pre-shrink pos", int'(scroll_pos), 10);
      msg_len = 5'd8;
      cycle();
      chk("shrink wrap", int'(wrap_pulse), 0);
      cycle();
      chk("shrink pos", int'(scroll_pos), 0);
      chk("shrink wrap2", int'(wrap_pulse), 0);

      // asynchronous reset between clock edges
      msg_len = 5'd18;
      enable  = 1'b1;
      wr_en   = 1'b1;
      wr_addr = 5'd2;
      wr_data = 5'd7;
      cycle();
      wr_en = 1'b0;
      repeat (6) cycle();
      #2 resetn = 1'b0;
      #1;
      model_reset();
      chk("async pos", int'(scroll_pos), 0);
      chk("async wrap", int'(wrap_pulse), 0);
      chk("async d5", dig(5), 17);
      chk("async d4", dig(4), 16);
      chk("async d3", dig(3), 15);
      chk("async d0", dig(0), 12);
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      resetn = 1'b1;
      repeat (4) cycle();
      chk("post-reset hold", int'(scroll_pos), 0);
      cycle();
      chk("post-reset tick", int'(scroll_pos), 1);

      // randomized traffic against the model
      for (int n = 0; n < 800; n++) begin
         enable = ($urandom_range(0, 3) != 0);
         dir    = 1'($urandom_range(0, 1));
         step   = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0)
            msg_len = 5'($urandom_range(0, 31));
         wr_en   = ($urandom_range(0, 3) == 0);
         wr_addr = 5'($urandom_range(0, 31));
         wr_data = 5'($urandom_range(0, 31));
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
